// File: rtl/snax_wide_bank_initiator.sv
// Splits one wide DMA read/write into per-bank narrow requests and reassembles read data.
// Optional macro SNAX_WIDE_INIT_STRB_SKIP_EN: writes skip banks whose strobe slice is all zero.
module snax_wide_bank_lane #(
  parameter int unsigned   AW     = 48,
  parameter int unsigned   NW     = 32,
  parameter logic [AW-1:0] OFFSET = '0
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            accept_i,
  input  logic            init_pend_i,
  input  logic            issue_i,
  input  logic            write_i,
  input  logic [AW-1:0]   base_i,
  input  logic [NW-1:0]   wdata_i,
  input  logic [NW/8-1:0] strb_i,
  input  logic            q_ready_i,
  input  logic [NW-1:0]   p_data_i,
  output logic            q_valid_o,
  output logic [AW-1:0]   q_addr_o,
  output logic            q_write_o,
  output logic [NW-1:0]   q_data_o,
  output logic [NW/8-1:0] q_strb_o,
  output logic            pend_d_o,
  output logic [NW-1:0]   rdata_o
);
  logic            pend_q, pend_d, cap_q, cap_d, grant;
  logic [NW-1:0]   wdata_q, buf_q;
  logic [NW/8-1:0] strb_q;

  assign q_valid_o = issue_i & pend_q;
  assign grant     = q_valid_o & q_ready_i;
  assign cap_d     = grant & ~write_i;
  assign pend_d_o  = pend_d;
  assign rdata_o   = buf_q;

  always_comb begin
    pend_d = pend_q;
    if (accept_i)   pend_d = init_pend_i;
    else if (grant) pend_d = 1'b0;
  end

  // Request fields are only driven while issuing so idle outputs read as zero.
  assign q_addr_o  = issue_i ? base_i + OFFSET : '0;
  assign q_write_o = issue_i & write_i;
  assign q_data_o  = issue_i ? wdata_q : '0;
  assign q_strb_o  = issue_i ? strb_q : '0;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pend_q  <= 1'b0;
      cap_q   <= 1'b0;
      wdata_q <= '0;
      strb_q  <= '0;
      buf_q   <= '0;
    end else begin
      pend_q <= pend_d;
      cap_q  <= cap_d;
      if (accept_i) begin
        wdata_q <= wdata_i;
        strb_q  <= strb_i;
      end
      // Bank read data arrives one cycle after its grant.
      if (cap_q) buf_q <= p_data_i;
    end
  end
endmodule

module snax_wide_bank_initiator #(
  parameter int unsigned NarrowDataWidth = 32,
  parameter int unsigned WideDataWidth   = 512,
  parameter int unsigned AddrWidth       = 48,
  parameter int unsigned NumBanks        = WideDataWidth / NarrowDataWidth
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                wide_req_valid_i,
  output logic                                wide_req_ready_o,
  input  logic [AddrWidth-1:0]                wide_req_addr_i,
  input  logic                                wide_req_write_i,
  input  logic [WideDataWidth-1:0]            wide_req_wdata_i,
  input  logic [WideDataWidth/8-1:0]          wide_req_strb_i,
  output logic                                wide_rsp_valid_o,
  input  logic                                wide_rsp_ready_i,
  output logic [WideDataWidth-1:0]            wide_rsp_rdata_o,
  output logic [NumBanks-1:0]                 bank_q_valid_o,
  input  logic [NumBanks-1:0]                 bank_q_ready_i,
  output logic [NumBanks*AddrWidth-1:0]       bank_q_addr_o,
  output logic [NumBanks-1:0]                 bank_q_write_o,
  output logic [NumBanks*NarrowDataWidth-1:0] bank_q_data_o,
  output logic [NumBanks*NarrowDataWidth/8-1:0] bank_q_strb_o,
  input  logic [NumBanks*NarrowDataWidth-1:0] bank_p_data_i,
  output logic                                dma_access_o
);
  localparam int unsigned   SW        = NarrowDataWidth / 8;
  localparam logic [AddrWidth-1:0] AlignMask = ~(AddrWidth'(WideDataWidth / 8 - 1));

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  state_e state_q, state_d;

  logic [AddrWidth-1:0] base_q;
  logic                 write_q, accept, issue;
  logic [NumBanks-1:0]  init_pend, pend_d;
  logic [NumBanks-1:0][AddrWidth-1:0]       addr;
  logic [NumBanks-1:0][NarrowDataWidth-1:0] qdata, rdata;
  logic [NumBanks-1:0][SW-1:0]              qstrb;

  assign wide_req_ready_o = (state_q == IDLE) & ~rst_i;
  assign accept           = wide_req_valid_i & wide_req_ready_o;
  assign issue            = (state_q == ISSUE);
  assign wide_rsp_valid_o = (state_q == RESP);
  assign wide_rsp_rdata_o = rdata;
  assign dma_access_o     = (state_q != IDLE);
  assign bank_q_addr_o    = addr;
  assign bank_q_data_o    = qdata;
  assign bank_q_strb_o    = qstrb;

  for (genvar i = 0; i < NumBanks; i++) begin : g_lane
`ifdef SNAX_WIDE_INIT_STRB_SKIP_EN
    assign init_pend[i] = ~(wide_req_write_i & (wide_req_strb_i[i*SW +: SW] == '0));
`else
    assign init_pend[i] = 1'b1;
`endif
    snax_wide_bank_lane #(
      .AW    (AddrWidth),
      .NW    (NarrowDataWidth),
      .OFFSET(AddrWidth'(i * SW))
    ) u_lane (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .accept_i   (accept),
      .init_pend_i(init_pend[i]),
      .issue_i    (issue),
      .write_i    (write_q),
      .base_i     (base_q),
      .wdata_i    (wide_req_wdata_i[i*NarrowDataWidth +: NarrowDataWidth]),
      .strb_i     (wide_req_strb_i[i*SW +: SW]),
      .q_ready_i  (bank_q_ready_i[i]),
      .p_data_i   (bank_p_data_i[i*NarrowDataWidth +: NarrowDataWidth]),
      .q_valid_o  (bank_q_valid_o[i]),
      .q_addr_o   (addr[i]),
      .q_write_o  (bank_q_write_o[i]),
      .q_data_o   (qdata[i]),
      .q_strb_o   (qstrb[i]),
      .pend_d_o   (pend_d[i]),
      .rdata_o    (rdata[i])
    );
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = ISSUE;
      // WAIT gives the final grants one cycle to land in the buffer.
      ISSUE:   if (pend_d == '0) state_d = write_q ? IDLE : WAIT;
      WAIT:    state_d = RESP;
      RESP:    if (wide_rsp_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      base_q  <= '0;
      write_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        base_q  <= wide_req_addr_i & AlignMask;
        write_q <= wide_req_write_i;
      end
    end
  end
endmodule
